// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared scancodes, JOY bit map and coin FSM types
package arcade_input_pkg;

  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_P1_JUMP  = 8'h29;
  localparam logic [7:0] SC_P1_FIRE  = 8'h14;
  localparam logic [7:0] SC_F1       = 8'h05;
  localparam logic [7:0] SC_1        = 8'h16;
  localparam logic [7:0] SC_F2       = 8'h06;
  localparam logic [7:0] SC_2        = 8'h1E;
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_FIRE  = 8'h1C;
  localparam logic [7:0] SC_P2_JUMP  = 8'h1B;
  localparam logic [7:0] SC_COIN_5   = 8'h2E;
  localparam logic [7:0] SC_COIN_6   = 8'h36;

  localparam int J_RIGHT = 0;
  localparam int J_LEFT  = 1;
  localparam int J_DOWN  = 2;
  localparam int J_UP    = 3;
  localparam int J_FIRE  = 4;
  localparam int J_JUMP  = 5;
  localparam int J_START = 6;
  localparam int J_COIN  = 7;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  typedef struct packed {
    logic p1_up, p1_down, p1_left, p1_right, p1_jump, p1_fire;
    logic start1_f1, start1_1, start2_f2, start2_2;
    logic p2_up, p2_down, p2_left, p2_right, p2_fire, p2_jump;
    logic coin_5, coin_6;
  } key_state_t;

  // Opposing directions cancel: both asserted reads as neither.
  function automatic logic [1:0] socd(input logic a, input logic b);
    return {a & ~b, b & ~a};
  endfunction

endpackage

// File: rtl/arcade_input_cond_coin_pulser.sv
// rtl/arcade_input_cond_coin_pulser.sv - coin request edge detect, 3-deep pending queue, pulse/gap FSM
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 3000000,
  parameter int COIN_GAP_CYC   = 1500000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin,
  output logic busy
);

  localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PULSE_LOAD = cnt_t'(COIN_PULSE_CYC - 1);
  localparam cnt_t GAP_LOAD   = cnt_t'(COIN_GAP_CYC - 1);

  coin_state_t state, state_nxt;
  cnt_t        cnt, cnt_nxt;
  logic [1:0]  pending, pending_nxt;
  logic        req_q;
  logic        rise, queue, consume;

  assign rise = req & ~req_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      req_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      req_q   <= req;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        if (rise || pending != 2'd0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LOAD;
          consume   = (pending != 2'd0);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (pending != 2'd0) begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LOAD;
            consume   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A request that cannot start a pulse right away is queued; a simultaneous consume cancels it out.
    queue       = rise && (state != IDLE || pending != 2'd0);
    pending_nxt = pending;
    if (queue && !consume && pending != 2'd3)
      pending_nxt = pending + 2'd1;
    else if (consume && !queue)
      pending_nxt = pending - 2'd1;
  end

  always_comb begin
    coin = (state == PULSE);
    busy = (state != IDLE) || (pending != 2'd0);
  end

endmodule

// File: rtl/arcade_input_cond.sv
// rtl/arcade_input_cond.sv - PS/2 key decode, joystick merge with SOCD, registered JOY outputs
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 3000000,
  parameter int COIN_GAP_CYC   = 1500000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        inputs_en,
  output logic [7:0]  joy1_out,
  output logic [7:0]  joy2_out,
  output logic        coin_busy
);

  logic       tog_q;
  key_state_t keys;
  logic       ev, pressed, ext;
  logic [7:0] code;
  logic [7:0] p1, p2;
  logic       coin, coin_req;
  logic       unused_joy_hi;

  assign ev      = ps2_key[10] ^ tog_q;
  assign pressed = ps2_key[9];
  assign ext     = ps2_key[8];
  assign code    = ps2_key[7:0];
  assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
      keys  <= '0;
    end else begin
      tog_q <= ps2_key[10];
      if (ev) begin
        // Arrows arrive with or without the E0 prefix; everything else must be a plain code.
        case (code)
          SC_UP:    keys.p1_up    <= pressed;
          SC_DOWN:  keys.p1_down  <= pressed;
          SC_LEFT:  keys.p1_left  <= pressed;
          SC_RIGHT: keys.p1_right <= pressed;
          default: begin
            if (!ext) begin
              case (code)
                SC_P1_JUMP:  keys.p1_jump   <= pressed;
                SC_P1_FIRE:  keys.p1_fire   <= pressed;
                SC_F1:       keys.start1_f1 <= pressed;
                SC_1:        keys.start1_1  <= pressed;
                SC_F2:       keys.start2_f2 <= pressed;
                SC_2:        keys.start2_2  <= pressed;
                SC_P2_UP:    keys.p2_up     <= pressed;
                SC_P2_DOWN:  keys.p2_down   <= pressed;
                SC_P2_LEFT:  keys.p2_left   <= pressed;
                SC_P2_RIGHT: keys.p2_right  <= pressed;
                SC_P2_FIRE:  keys.p2_fire   <= pressed;
                SC_P2_JUMP:  keys.p2_jump   <= pressed;
                SC_COIN_5:   keys.coin_5    <= pressed;
                SC_COIN_6:   keys.coin_6    <= pressed;
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign coin_req = (keys.coin_5 | keys.coin_6 | joystick_0[J_COIN] | joystick_1[J_COIN]) & inputs_en;

  coin_pulser #(
    .COIN_PULSE_CYC(COIN_PULSE_CYC),
    .COIN_GAP_CYC  (COIN_GAP_CYC)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .req    (coin_req),
    .coin   (coin),
    .busy   (coin_busy)
  );

  always_comb begin
    p1 = '0;
    p2 = '0;
    p1[J_RIGHT] = keys.p1_right | joystick_0[J_RIGHT];
    p1[J_LEFT]  = keys.p1_left  | joystick_0[J_LEFT];
    p1[J_DOWN]  = keys.p1_down  | joystick_0[J_DOWN];
    p1[J_UP]    = keys.p1_up    | joystick_0[J_UP];
    p1[J_FIRE]  = keys.p1_fire  | joystick_0[J_FIRE];
    p1[J_JUMP]  = keys.p1_jump  | joystick_0[J_JUMP];
    p1[J_START] = keys.start1_f1 | keys.start1_1 | joystick_0[J_START];
    p1[J_COIN]  = coin;
    p2[J_RIGHT] = keys.p2_right | joystick_1[J_RIGHT];
    p2[J_LEFT]  = keys.p2_left  | joystick_1[J_LEFT];
    p2[J_DOWN]  = keys.p2_down  | joystick_1[J_DOWN];
    p2[J_UP]    = keys.p2_up    | joystick_1[J_UP];
    p2[J_FIRE]  = keys.p2_fire  | joystick_1[J_FIRE];
    p2[J_JUMP]  = keys.p2_jump  | joystick_1[J_JUMP];
    p2[J_START] = keys.start2_f2 | keys.start2_2 | joystick_1[J_START];
    {p1[J_UP], p1[J_DOWN]}    = socd(p1[J_UP], p1[J_DOWN]);
    {p1[J_LEFT], p1[J_RIGHT]} = socd(p1[J_LEFT], p1[J_RIGHT]);
    {p2[J_UP], p2[J_DOWN]}    = socd(p2[J_UP], p2[J_DOWN]);
    {p2[J_LEFT], p2[J_RIGHT]} = socd(p2[J_LEFT], p2[J_RIGHT]);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy1_out <= '0;
      joy2_out <= '0;
    end else if (inputs_en) begin
      joy1_out <= p1;
      joy2_out <= p2;
    end else begin
      joy1_out <= '0;
      joy2_out <= '0;
    end
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
// tb/tb_arcade_input_cond.sv - randomized self-checking bench for arcade_input_cond
`timescale 1ns/1ps
module tb_arcade_input_cond;

  localparam int PULSE = 8;
  localparam int GAP   = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0;
  logic [15:0] joystick_1 = '0;
  logic        inputs_en = 1'b1;
  logic [7:0]  joy1_out, joy2_out;
  logic        coin_busy;

  int checks = 0;
  int errors = 0;

  bit held [0:255];
  bit mon_en = 1'b0;
  bit coin_trace[$];
  bit busy_trace[$];
  int hi_runs[$];
  int gap_runs[$];
  int tail_low;
  int busy_cycles;

  arcade_input_cond #(.COIN_PULSE_CYC(PULSE), .COIN_GAP_CYC(GAP)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .inputs_en (inputs_en),
    .joy1_out  (joy1_out),
    .joy2_out  (joy2_out),
    .coin_busy (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (mon_en) begin
      coin_trace.push_back(joy1_out[7]);
      busy_trace.push_back(coin_busy);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  function automatic bit is_arrow(input logic [7:0] c);
    return (c == 8'h75) || (c == 8'h72) || (c == 8'h6B) || (c == 8'h74);
  endfunction

  function automatic bit is_mapped(input logic [7:0] c);
    case (c)
      8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E,
      8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h2E, 8'h36: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic key_event(input bit pressed, input bit ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    if (is_mapped(code) && (is_arrow(code) || !ext)) held[code] = pressed;
  endtask

  function automatic logic [7:0] exp_p1(input bit coin);
    bit up, dn, lf, rt, fire, jump, st;
    up   = held[8'h75] | joystick_0[3];
    dn   = held[8'h72] | joystick_0[2];
    lf   = held[8'h6B] | joystick_0[1];
    rt   = held[8'h74] | joystick_0[0];
    fire = held[8'h14] | joystick_0[4];
    jump = held[8'h29] | joystick_0[5];
    st   = held[8'h05] | held[8'h16] | joystick_0[6];
    return inputs_en ? {coin, st, jump, fire, up & ~dn, dn & ~up, lf & ~rt, rt & ~lf} : 8'h00;
  endfunction

  function automatic logic [7:0] exp_p2();
    bit up, dn, lf, rt, fire, jump, st;
    up   = held[8'h2D] | joystick_1[3];
    dn   = held[8'h2B] | joystick_1[2];
    lf   = held[8'h23] | joystick_1[1];
    rt   = held[8'h34] | joystick_1[0];
    fire = held[8'h1C] | joystick_1[4];
    jump = held[8'h1B] | joystick_1[5];
    st   = held[8'h06] | held[8'h1E] | joystick_1[6];
    return inputs_en ? {1'b0, st, jump, fire, up & ~dn, dn & ~up, lf & ~rt, rt & ~lf} : 8'h00;
  endfunction

  task automatic do_reset();
    reset_n    = 1'b0;
    ps2_key    = '0;
    joystick_0 = '0;
    joystick_1 = '0;
    inputs_en  = 1'b1;
    foreach (held[i]) held[i] = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic start_trace();
    coin_trace.delete();
    busy_trace.delete();
    mon_en = 1'b1;
  endtask

  task automatic analyse();
    int hl, ll;
    bit seen;
    hl = 0; ll = 0; seen = 1'b0;
    hi_runs.delete();
    gap_runs.delete();
    busy_cycles = 0;
    foreach (busy_trace[i]) busy_cycles += busy_trace[i];
    foreach (coin_trace[i]) begin
      if (coin_trace[i]) begin
        if (ll > 0 && seen) gap_runs.push_back(ll);
        ll = 0; hl++; seen = 1'b1;
      end else begin
        if (hl > 0) hi_runs.push_back(hl);
        hl = 0; ll++;
      end
    end
    if (hl > 0) hi_runs.push_back(hl);
    tail_low = ll;
  endtask

  task automatic wait_busy_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!coin_busy) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_coin_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (joy1_out[7]) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++; if (joy1_out !== 8'h00) begin errors++; $display("FAIL reset_joy1: got %h expected 00", joy1_out); end
    checks++; if (joy2_out !== 8'h00) begin errors++; $display("FAIL reset_joy2: got %h expected 00", joy2_out); end
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", coin_busy); end
    do_reset();
  endtask

  task automatic test_key_arrow();
    key_event(1'b1, 1'b1, 8'h75);
    tick(1);
    checks++; if (joy1_out[3] !== 1'b0) begin errors++; $display("FAIL key_latency: got %b expected 0 after one edge", joy1_out[3]); end
    tick(1);
    checks++; if (joy1_out !== 8'h08) begin errors++; $display("FAIL key_up_press: got %h expected 08", joy1_out); end
    key_event(1'b0, 1'b1, 8'h75);
    tick(2);
    checks++; if (joy1_out !== 8'h00) begin errors++; $display("FAIL key_up_release: got %h expected 00", joy1_out); end
  endtask

  task automatic test_socd();
    joystick_0 = 16'h000C;
    tick(1);
    checks++; if (joy1_out[3:2] !== 2'b00) begin errors++; $display("FAIL socd_updown: got %b expected 00", joy1_out[3:2]); end
    joystick_0 = 16'h0008;
    tick(1);
    checks++; if (joy1_out !== 8'h08) begin errors++; $display("FAIL socd_release: got %h expected 08", joy1_out); end
    joystick_0 = 16'h0001;
    key_event(1'b1, 1'b0, 8'h6B);
    tick(2);
    checks++; if (joy1_out !== 8'h00) begin errors++; $display("FAIL socd_leftright: got %h expected 00", joy1_out); end
    key_event(1'b0, 1'b0, 8'h6B);
    joystick_0 = 16'h0000;
    tick(2);
  endtask

  task automatic test_ext_filter();
    key_event(1'b1, 1'b1, 8'h23);
    tick(2);
    checks++; if (joy2_out !== 8'h00) begin errors++; $display("FAIL ext_ignored: got %h expected 00", joy2_out); end
    key_event(1'b1, 1'b0, 8'h23);
    tick(2);
    checks++; if (joy2_out !== 8'h02) begin errors++; $display("FAIL p2_left: got %h expected 02", joy2_out); end
    checks++; if (joy1_out !== 8'h00) begin errors++; $display("FAIL p2_left_joy1: got %h expected 00", joy1_out); end
    key_event(1'b0, 1'b0, 8'h23);
    tick(2);
  endtask

  task automatic test_random_keys();
    logic [7:0] codes [0:19];
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E,
              8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h1D, 8'h3C, 8'h15, 8'h7D};
    for (int it = 0; it < 40; it++) begin
      key_event(1'($urandom), 1'($urandom), codes[$urandom_range(19, 0)]);
      joystick_0    = 16'($urandom);
      joystick_0[7] = 1'b0;
      joystick_1    = 16'($urandom);
      joystick_1[7] = 1'b0;
      tick(2);
      checks++; if (joy1_out !== exp_p1(1'b0)) begin errors++; $display("FAIL rand_joy1[%0d]: got %h expected %h", it, joy1_out, exp_p1(1'b0)); end
      checks++; if (joy2_out !== exp_p2()) begin errors++; $display("FAIL rand_joy2[%0d]: got %h expected %h", it, joy2_out, exp_p2()); end
    end
    do_reset();
  endtask

  task automatic test_coin_single();
    bit ok;
    start_trace();
    joystick_0[7] = 1'b1;
    tick(3);
    joystick_0[7] = 1'b0;
    wait_busy_low(ok);
    tick(6);
    mon_en = 1'b0;
    analyse();
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: busy still %b expected 0", coin_busy); end
    checks++; if (hi_runs.size() != 1) begin errors++; $display("FAIL single_count: got %0d pulses expected 1", hi_runs.size()); end
    checks++; if (hi_runs.size() > 0 && hi_runs[0] != PULSE) begin errors++; $display("FAIL single_len: got %0d expected %0d", hi_runs[0], PULSE); end
    checks++; if (tail_low < GAP) begin errors++; $display("FAIL single_gap: got %0d low cycles expected >= %0d", tail_low, GAP); end
    checks++; if (busy_cycles != PULSE + GAP) begin errors++; $display("FAIL single_busy: got %0d busy cycles expected %0d", busy_cycles, PULSE + GAP); end
  endtask

  task automatic test_coin_burst(input int presses);
    bit ok;
    int exp_pulses, bad_len, bad_gap;
    logic [7:0] kc;
    exp_pulses = 1 + ((presses - 1 < 3) ? presses - 1 : 3);
    start_trace();
    for (int p = 0; p < presses; p++) begin
      kc = ($urandom_range(1, 0) != 0) ? 8'h2E : 8'h36;
      key_event(1'b1, 1'b0, kc);
      tick(1);
      key_event(1'b0, 1'b0, kc);
      tick(1);
    end
    wait_busy_low(ok);
    tick(4);
    mon_en = 1'b0;
    analyse();
    bad_len = 0;
    bad_gap = 0;
    foreach (hi_runs[i]) if (hi_runs[i] != PULSE) bad_len++;
    foreach (gap_runs[i]) if (gap_runs[i] != GAP) bad_gap++;
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout[%0d]: busy still %b expected 0", presses, coin_busy); end
    checks++; if (hi_runs.size() != exp_pulses) begin errors++; $display("FAIL burst_count[%0d]: got %0d pulses expected %0d", presses, hi_runs.size(), exp_pulses); end
    checks++; if (bad_len != 0) begin errors++; $display("FAIL burst_len[%0d]: got %0d wrong-length pulses expected 0", presses, bad_len); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL burst_gap[%0d]: got %0d wrong gaps expected 0", presses, bad_gap); end
  endtask

  task automatic test_inputs_en();
    bit ok;
    int highs;
    inputs_en  = 1'b0;
    joystick_0 = 16'h0018;
    tick(1);
    checks++; if (joy1_out !== 8'h00) begin errors++; $display("FAIL en_forced: got %h expected 00", joy1_out); end
    start_trace();
    joystick_0 = 16'h0080;
    tick(20);
    mon_en = 1'b0;
    analyse();
    highs = hi_runs.size();
    checks++; if (highs != 0 || busy_cycles != 0) begin errors++; $display("FAIL en_coin_drop: got %0d pulses %0d busy expected 0 0", highs, busy_cycles); end
    joystick_0 = 16'h0000;
    tick(2);
    inputs_en = 1'b1;
    tick(2);
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL en_restore: got %b expected 0", coin_busy); end
    joystick_0[7] = 1'b1;
    wait_coin_high(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_mid_start: got %b expected coin 1", joy1_out[7]); end
    inputs_en = 1'b0;
    joystick_0 = 16'h0000;
    tick(2);
    checks++; if (joy1_out[7] !== 1'b0) begin errors++; $display("FAIL en_mid_coin: got %b expected 0", joy1_out[7]); end
    checks++; if (coin_busy !== 1'b1) begin errors++; $display("FAIL en_mid_busy: got %b expected 1", coin_busy); end
    inputs_en = 1'b1;
    wait_busy_low(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_mid_finish: busy still %b expected 0", coin_busy); end
  endtask

  task automatic test_reset_mid_pulse();
    bit ok;
    key_event(1'b1, 1'b0, 8'h1C);
    joystick_0[7] = 1'b1;
    wait_coin_high(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_start: got %b expected coin 1", joy1_out[7]); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (joy1_out !== 8'h00) begin errors++; $display("FAIL rst_mid_joy1: got %h expected 00", joy1_out); end
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", coin_busy); end
    checks++; if (joy2_out !== 8'h00) begin errors++; $display("FAIL rst_mid_joy2: got %h expected 00", joy2_out); end
    do_reset();
    tick(2);
    checks++; if (joy2_out !== 8'h00) begin errors++; $display("FAIL rst_keys_cleared: got %h expected 00", joy2_out); end
  endtask

  initial begin
    test_reset();
    test_key_arrow();
    test_socd();
    test_ext_filter();
    test_random_keys();
    test_coin_single();
    test_coin_burst(5);
    test_coin_burst($urandom_range(4, 1));
    test_inputs_en();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
